// File: rtl/score_display_n.sv
// score_display_n: binary score -> BCD (sequential double-dabble) -> seven-segment pixel renderer.
// Digits are latched atomically at the end of each conversion, so the picture never tears.
// Handshake: i_ani_stb is a one-cycle request; it is accepted immediately when idle, otherwise it
// is remembered in a single pending flag and serviced right after the current conversion latches.
module score_display_n #(
    parameter int BIN_W    = 14,
    parameter int DIGITS   = 4,
    parameter int X0       = 10,
    parameter int Y0       = 50,
    parameter int DIG_W    = 26,
    parameter int DIG_H    = 51,
    parameter int DIG_GAP  = 10,
    parameter int SEG_T    = 3,
    parameter int BLANK_LZ = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ani_stb,
    input  logic [BIN_W-1:0]      i_score,
    input  logic [9:0]            i_x,
    input  logic [9:0]            i_y,
    output logic                  o_pix,
    output logic                  o_busy,
    output logic                  o_ovf,
    output logic [4*DIGITS-1:0]   o_bcd
);

    // Enough BCD nibbles to hold any BIN_W-bit value exactly: ceil(BIN_W*0.302)+1
    localparam int NB    = (BIN_W * 302 + 999) / 1000 + 1;
    localparam int SR_W  = 4 * NB + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int PITCH = DIG_W + DIG_GAP;
    localparam int YM    = Y0 + (DIG_H - SEG_T) / 2;
    localparam int YB    = Y0 + DIG_H - SEG_T;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;

    state_t              state, state_nx;
    logic [SR_W-1:0]     sr, sr_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic                pending, pending_nx;
    logic                busy_nx;
    logic                ovf_nx;
    logic [4*DIGITS-1:0] bcd_nx;
    logic                big;
    logic [4*(NB+DIGITS)+BIN_W-1:0] sr_ext;
    logic                pix_nx;
    logic                lead_zero;
    int                  x_int;
    int                  y_int;

    // One double-dabble step: correct every nibble >= 5 by +3, then shift the whole register left.
    function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] r);
        logic [SR_W-1:0] t;
        t = r;
        for (int n = 0; n < NB; n++) begin
            if (t[BIN_W+4*n +: 4] >= 4'd5) t[BIN_W+4*n +: 4] = t[BIN_W+4*n +: 4] + 4'd3;
        end
        return t << 1;
    endfunction

    // Segment set per decimal digit, bit order {g,f,e,d,c,b,a}; 10..15 draw nothing.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h00;
        endcase
    endfunction

    // True when (x,y) lies on a lit segment of a digit whose left edge is xl.
    function automatic logic digit_hit(input int x, input int y, input int xl, input logic [6:0] seg);
        int   xr;
        logic in_full, in_l, in_r, ya, yg, yd, yup, ylo;
        xr      = xl + DIG_W - 1;
        in_full = (x >= xl) && (x <= xr);
        in_l    = (x >= xl) && (x <= xl + SEG_T - 1);
        in_r    = (x >= xr - SEG_T + 1) && (x <= xr);
        ya      = (y >= Y0) && (y <= Y0 + SEG_T - 1);
        yg      = (y >= YM) && (y <= YM + SEG_T - 1);
        yd      = (y >= YB) && (y <= YB + SEG_T - 1);
        yup     = (y >= Y0) && (y <= YM + SEG_T - 1);
        ylo     = (y >= YM) && (y <= YB + SEG_T - 1);
        return (seg[0] & in_full & ya) | (seg[1] & in_r & yup) | (seg[2] & in_r & ylo) |
               (seg[3] & in_full & yd) | (seg[4] & in_l & ylo) | (seg[5] & in_l & yup) |
               (seg[6] & in_full & yg);
    endfunction

    assign x_int  = int'({22'd0, i_x});
    assign y_int  = int'({22'd0, i_y});
    assign sr_ext = {{(4*DIGITS){1'b0}}, sr};

    // Overflow: any converted nibble above the displayed digits is non-zero.
    always_comb begin
        big = 1'b0;
        for (int n = DIGITS; n < NB; n++) begin
            if (sr[BIN_W+4*n +: 4] != 4'd0) big = 1'b1;
        end
    end

    // Conversion FSM: next state, shift register, pending flag and latched outputs.
    always_comb begin
        state_nx   = state;
        sr_nx      = sr;
        cnt_nx     = cnt;
        pending_nx = pending;
        busy_nx    = o_busy;
        bcd_nx     = o_bcd;
        ovf_nx     = o_ovf;
        case (state)
            S_IDLE: begin
                if (i_ani_stb) begin
                    sr_nx    = {{(4*NB){1'b0}}, i_score};
                    cnt_nx   = CNT_W'(BIN_W);
                    busy_nx  = 1'b1;
                    state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sr_nx  = dabble(sr);
                cnt_nx = cnt - CNT_W'(1);
                if (i_ani_stb) pending_nx = 1'b1;
                if (cnt == CNT_W'(1)) state_nx = S_LATCH;
            end
            S_LATCH: begin
                bcd_nx = big ? {DIGITS{4'h9}} : sr_ext[BIN_W +: 4*DIGITS];
                ovf_nx = big;
                if (pending || i_ani_stb) begin
                    // Back-to-back restart: busy stays high, fresh sample of i_score.
                    pending_nx = 1'b0;
                    sr_nx      = {{(4*NB){1'b0}}, i_score};
                    cnt_nx     = CNT_W'(BIN_W);
                    state_nx   = S_SHIFT;
                end else begin
                    busy_nx  = 1'b0;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Conversion state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_IDLE;
            sr      <= '0;
            cnt     <= '0;
            pending <= 1'b0;
            o_busy  <= 1'b0;
            o_bcd   <= '0;
            o_ovf   <= 1'b0;
        end else begin
            state   <= state_nx;
            sr      <= sr_nx;
            cnt     <= cnt_nx;
            pending <= pending_nx;
            o_busy  <= busy_nx;
            o_bcd   <= bcd_nx;
            o_ovf   <= ovf_nx;
        end
    end

    // Pixel decode: OR of lit segments over all non-blanked digits (leftmost = most significant).
    always_comb begin
        pix_nx    = 1'b0;
        lead_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            lead_zero = lead_zero & (o_bcd[4*(DIGITS-1-k) +: 4] == 4'd0);
            if (!((BLANK_LZ != 0) && lead_zero && (k < DIGITS - 1))) begin
                pix_nx = pix_nx | digit_hit(x_int, y_int, X0 + k * PITCH,
                                            glyph(o_bcd[4*(DIGITS-1-k) +: 4]));
            end
        end
    end

    // Registered pixel enable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) o_pix <= 1'b0;
        else       o_pix <= pix_nx;
    end

endmodule

// File: tb/tb_score_display_n.sv
// Bench for score_display_n (defaults: 14-bit score, 4 digits).
// A timing model predicts when each conversion lands and pushes its decimal result into a queue;
// a negedge monitor pops and compares. Pixel expectations come from a decimal/geometry model.
module tb_score_display_n;
  localparam int BIN_W = 14;
  localparam int X0 = 10, Y0 = 50, DIG_W = 26, DIG_H = 51, DIG_GAP = 10, T = 3;
  localparam int MID = (DIG_H - T) / 2;
  localparam int BOT = DIG_H - T;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stb = 1'b0;
  logic [BIN_W-1:0] score = '0;
  logic [9:0] x = '0, y = '0;
  logic pix, busy, ovf;
  logic [15:0] bcd;

  typedef struct { int due; int val; logic [15:0] bcd; logic ovf; } conv_t;
  typedef struct { int due; logic exp; } pix_t;
  conv_t conv_q[$];
  pix_t  pix_q[$];

  int cyc = 0;
  int n_tests = 0, n_fail = 0;
  bit m_active = 0, m_pend = 0;
  int m_done = 0;
  int disp_val = 0;
  string glyph_s[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                         "abcdefg", "abcdfg"};

  score_display_n dut (
    .i_clk(clk), .i_rst(rst), .i_ani_stb(stb), .i_score(score), .i_x(x), .i_y(y),
    .o_pix(pix), .o_busy(busy), .o_ovf(ovf), .o_bcd(bcd)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decimal result of a conversion, saturated to four digits.
  function automatic conv_t expect_of(input int v, input int due);
    conv_t e;
    int s;
    s = (v > 9999) ? 9999 : v;
    e.due = due;
    e.val = s;
    e.ovf = (v > 9999);
    e.bcd = 16'((s / 1000) * 4096 + ((s / 100) % 10) * 256 + ((s / 10) % 10) * 16 + s % 10);
    return e;
  endfunction

  // Pixel model: locate the digit cell, then test the glyph's segment letters.
  function automatic logic ref_pix(input int v, input int px, input int py);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int place, d, dx, dy;
      string s;
      place = 1;
      for (int j = 0; j < 3 - k; j++) place = place * 10;
      d  = (v / place) % 10;
      dx = px - (X0 + k * (DIG_W + DIG_GAP));
      dy = py - Y0;
      if (!(k < 3 && v < place) && dx >= 0 && dx < DIG_W && dy >= 0 && dy < DIG_H) begin
        s = glyph_s[d];
        for (int i = 0; i < s.len(); i++) begin
          case (s[i])
            "a": if (dy < T) hit = 1'b1;
            "g": if (dy >= MID && dy < MID + T) hit = 1'b1;
            "d": if (dy >= BOT) hit = 1'b1;
            "f": if (dx < T && dy < MID + T) hit = 1'b1;
            "b": if (dx >= DIG_W - T && dy < MID + T) hit = 1'b1;
            "e": if (dx < T && dy >= MID) hit = 1'b1;
            "c": if (dx >= DIG_W - T && dy >= MID) hit = 1'b1;
            default: ;
          endcase
        end
      end
    end
    return hit;
  endfunction

  task automatic model_start(input int v);
    m_done   = cyc + BIN_W + 1;
    m_active = 1;
    conv_q.push_back(expect_of(v, m_done));
  endtask

  // Timing model: a conversion lands BIN_W+1 edges after it is accepted; requests meanwhile coalesce.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (m_active && cyc == m_done) begin
        if (m_pend || stb) begin
          m_pend = 0;
          model_start(int'(score));
        end else m_active = 0;
      end else if (m_active) begin
        if (stb) m_pend = 1;
      end else if (stb) model_start(int'(score));
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      conv_t e;
      pix_t p;
      check("busy", 32'(busy), 32'(m_active));
      while (conv_q.size() > 0 && conv_q[0].due < cyc) begin
        e = conv_q.pop_front();
        n_tests++; n_fail++;
        $display("FAIL conv_missing: result %0h due cycle %0d not seen", e.bcd, e.due);
      end
      if (conv_q.size() > 0 && conv_q[0].due == cyc) begin
        e = conv_q.pop_front();
        check("bcd", 32'(bcd), 32'(e.bcd));
        check("ovf", 32'(ovf), 32'(e.ovf));
        disp_val = e.val;
      end
      if (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
        p = pix_q.pop_front();
        check($sformatf("pix(%0d,%0d)", x, y), 32'(pix), 32'(p.exp));
      end
    end
  end

  // driver tasks
  task automatic strobe(input int v);
    @(posedge clk); #1;
    score = BIN_W'(v);
    stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!m_active && conv_q.size() == 0 && pix_q.size() == 0) return;
    end
    n_tests++; n_fail++;
    $display("FAIL idle_timeout: busy=%0d still pending after 300 cycles", busy);
  endtask

  task automatic probe(input int px, input int py);
    @(posedge clk); #1;
    x = 10'(px);
    y = 10'(py);
    pix_q.push_back('{due: cyc + 1, exp: ref_pix(disp_val, px, py)});
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_pix", 32'(pix), 32'd0);
    conv_q.delete();
    pix_q.delete();
    m_active = 0;
    m_pend = 0;
    disp_val = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic int rand_score();
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, 9);
      1: return $urandom_range(0, 999);
      2: return $urandom_range(0, 16383);
      default: return $urandom_range(9990, 10010);
    endcase
  endfunction

  initial begin
    apply_reset();

    // basic conversion and digit rendering
    strobe(1234); wait_idle();
    probe(118, 50); probe(10, 50); probe(20, 74); probe(60, 99); wait_idle();
    strobe(0); wait_idle();
    probe(118, 50); probe(120, 50); probe(10, 50); probe(130, 74); probe(143, 80); wait_idle();

    // saturation and the largest in-range value
    strobe(12000); wait_idle();
    strobe(9999); wait_idle();
    strobe(16383); wait_idle();

    // request coalescing: 5, then 77 requested twice while busy
    strobe(5);
    repeat (3) @(posedge clk);
    strobe(77);
    repeat (2) @(posedge clk);
    strobe(77);
    wait_idle();

    // segment g of the last digit
    strobe(8); wait_idle();
    probe(128, 74); probe(128, 73); probe(128, 77); wait_idle();
    strobe(0); wait_idle();
    probe(128, 74); wait_idle();

    // asynchronous reset in the middle of a conversion, with a lit pixel under the beam
    x = 10'd120; y = 10'd50;
    strobe(1234);
    repeat (5) @(posedge clk);
    #2 apply_reset();
    strobe(4321); wait_idle();

    // randomized conversions with overlapping requests and random pixel probes
    for (int it = 0; it < 40; it++) begin
      strobe(rand_score());
      for (int j = 0; j < int'($urandom_range(0, 20)); j++) begin
        @(posedge clk); #1;
        stb = ($urandom_range(0, 3) == 0);
        score = BIN_W'(rand_score());
      end
      #0 stb = 1'b0;
      wait_idle();
      for (int j = 0; j < 8; j++) probe($urandom_range(0, 170), $urandom_range(40, 110));
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
